// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and redirect-kind encodings for the fetch control slice.
//   DEF_ADDR_W    : default instruction-address width
//   DEF_RAS_DEPTH : default return-address-stack depth
//   br_kind_e     : redirect kinds carried on br_kind (values 5-7 are reserved)
package fetch_pkg;

    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_RAS_DEPTH = 8;

    typedef enum logic [2:0] {
        BR_JR   = 3'd0,
        BR_JPC  = 3'd1,
        BR_BRFL = 3'd2,
        BR_CALL = 3'd3,
        BR_RET  = 3'd4
    } br_kind_e;

endpackage

// File: rtl/return_stack.sv
// return_stack: LIFO of return addresses.
//   clk, rst_n : clock, async active-low reset (empties the stack)
//   push, din  : write din on top; ignored when full
//   pop        : discard top entry; ignored when empty
//   top        : current top entry (zero when empty)
//   full, empty: occupancy flags
// The caller never asserts push and pop in the same cycle.
module return_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [SP_W-1:0]  sp;          // number of valid entries
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] wr_idx;

    assign full    = (sp == SP_W'(DEPTH));
    assign empty   = (sp == '0);
    assign top_idx = IDX_W'(sp - 1'b1);
    assign wr_idx  = IDX_W'(sp);
    assign top     = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end

    // Storage needs no reset: entries above sp are never read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/fetch_control.sv
// fetch_control: program counter and redirect handling for the fetch stage.
//   clk, rst_n     : clock, async active-low reset
//   stall          : hold pc_out / if_pc / if_valid (a redirect still wins)
//   br_valid       : one-cycle redirect request from execute
//   br_kind        : JR / JPC / BRFL / CALL / RET (5-7 reserved -> no redirect)
//   br_target      : absolute target, or signed offset for JPC
//   br_pc          : address of the redirecting instruction
//   pc_out         : fetch address into the 1-cycle synchronous instruction memory
//   if_pc          : address of the word memory is presenting this cycle
//   if_valid       : presented word is valid and not flushed
//   ras_overflow   : sticky, CALL seen while the return stack was full
//   ras_underflow  : sticky, RET seen while the return stack was empty
module fetch_control
    import fetch_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              br_valid,
    input  logic [2:0]        br_kind,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] br_pc,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    logic              redirect;
    logic [ADDR_W-1:0] redir_pc;
    logic              ras_push;
    logic              ras_pop;
    logic              call_full;
    logic              ret_empty;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_full;
    logic              ras_empty;

    always_comb begin
        redirect  = 1'b0;
        redir_pc  = '0;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        call_full = 1'b0;
        ret_empty = 1'b0;
        if (br_valid) begin
            case (br_kind)
                BR_JR, BR_BRFL: begin
                    redirect = 1'b1;
                    redir_pc = br_target;
                end
                // Offset and PC share one width, so wrapping addition of the
                // raw offset equals adding its sign extension modulo 2^ADDR_W.
                BR_JPC: begin
                    redirect = 1'b1;
                    redir_pc = br_pc + ADDR_W'(1) + br_target;
                end
                BR_CALL: begin
                    redirect  = 1'b1;
                    redir_pc  = br_target;
                    ras_push  = !ras_full;
                    call_full = ras_full;
                end
                BR_RET: begin
                    redirect  = 1'b1;
                    redir_pc  = ras_empty ? '0 : ras_top;
                    ras_pop   = !ras_empty;
                    ret_empty = ras_empty;
                end
                default: ;  // reserved kinds fall through to sequential/stall
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out        <= '0;
            if_pc         <= '0;
            if_valid      <= 1'b0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            if (redirect) begin
                // Word already in flight is from the wrong path: flush it.
                pc_out   <= redir_pc;
                if_pc    <= pc_out;
                if_valid <= 1'b0;
            end else if (!stall) begin
                pc_out   <= pc_out + ADDR_W'(1);
                if_pc    <= pc_out;
                if_valid <= 1'b1;
            end
            if (call_full) ras_overflow  <= 1'b1;
            if (ret_empty) ras_underflow <= 1'b1;
        end
    end

    return_stack #(
        .W     (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (br_pc + ADDR_W'(1)),
        .top   (ras_top),
        .full  (ras_full),
        .empty (ras_empty)
    );

endmodule

// File: tb/tb_fetch_control.sv
// tb_fetch_control: scoreboard bench for fetch_control (ADDR_W=8, RAS_DEPTH=8).
// Each step drives inputs, pushes the expected post-edge outputs from a small
// reference model, then pops and compares them after the edge.
module tb_fetch_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stall;
    logic       br_valid;
    logic [2:0] br_kind;
    logic [7:0] br_target;
    logic [7:0] br_pc;
    logic [7:0] pc_out;
    logic [7:0] if_pc;
    logic       if_valid;
    logic       ras_overflow;
    logic       ras_underflow;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] ifpc;
        logic       ifv;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_stk[$];
    logic [7:0] m_pc, m_ifpc;
    logic       m_ifv, m_ovf, m_unf;
    int         total = 0;
    int         bad   = 0;

    fetch_control #(.ADDR_W(8), .RAS_DEPTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .br_valid      (br_valid),
        .br_kind       (br_kind),
        .br_target     (br_target),
        .br_pc         (br_pc),
        .pc_out        (pc_out),
        .if_pc         (if_pc),
        .if_valid      (if_valid),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'd0; m_ifpc = 8'd0; m_ifv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        m_stk.delete();
        sb.delete();
    endtask

    // Asserted away from the clock edge; outputs must clear without a clock.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_pc",   32'(pc_out),        32'd0);
        check("rst_ifpc", 32'(if_pc),         32'd0);
        check("rst_ifv",  32'(if_valid),      32'd0);
        check("rst_ovf",  32'(ras_overflow),  32'd0);
        check("rst_unf",  32'(ras_underflow), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic step(input logic s, input logic bv, input logic [2:0] k,
                        input logic [7:0] t, input logic [7:0] p);
        exp_t e;
        logic [7:0] npc;
        int off;
        stall = s; br_valid = bv; br_kind = k; br_target = t; br_pc = p;
        if (bv && k <= 3'd4) begin
            npc = 8'd0;
            case (k)
                3'd0, 3'd2: npc = t;
                3'd1: begin
                    off = t[7] ? int'(t) - 256 : int'(t);
                    npc = 8'((int'(p) + 1 + off + 512) % 256);
                end
                3'd3: begin
                    if (m_stk.size() == 8) m_ovf = 1'b1;
                    else m_stk.push_back(p + 8'd1);
                    npc = t;
                end
                default: begin
                    if (m_stk.size() == 0) begin
                        m_unf = 1'b1;
                        npc = 8'd0;
                    end else begin
                        npc = m_stk.pop_back();
                    end
                end
            endcase
            m_ifpc = m_pc; m_ifv = 1'b0; m_pc = npc;
        end else if (!s) begin
            m_ifpc = m_pc; m_pc = m_pc + 8'd1; m_ifv = 1'b1;
        end
        sb.push_back('{m_pc, m_ifpc, m_ifv, m_ovf, m_unf});
        @(posedge clk); #1;
        e = sb.pop_front();
        check("pc_out",   32'(pc_out),        32'(e.pc));
        check("if_pc",    32'(if_pc),         32'(e.ifpc));
        check("if_valid", 32'(if_valid),      32'(e.ifv));
        check("ovf",      32'(ras_overflow),  32'(e.ovf));
        check("unf",      32'(ras_underflow), 32'(e.unf));
        br_valid = 1'b0; stall = 1'b0;
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; br_valid = 1'b0;
        br_kind = 3'd0; br_target = 8'd0; br_pc = 8'd0;
        @(posedge clk); #1;
        do_reset();

        // Sequential start after reset
        seq(1); check("start_pc1", 32'(pc_out), 32'd1); check("start_ifpc0", 32'(if_pc), 32'd0);
        seq(2); check("start_pc3", 32'(pc_out), 32'd3); check("start_ifpc2", 32'(if_pc), 32'd2);

        // Stall alone for 3 cycles
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd0, 8'd0, 8'd0);
        check("stall_pc", 32'(pc_out), 32'd3);

        // Redirect overrides stall
        step(1'b1, 1'b1, 3'd0, 8'd68, 8'd2);
        check("jr_stall_pc", 32'(pc_out), 32'd68); check("jr_flush", 32'(if_valid), 32'd0);
        seq(1); check("jr_refill", 32'(if_valid), 32'd1);

        // PC-relative jumps, positive and negative offsets
        step(1'b0, 1'b1, 3'd1, 8'd5, 8'd41);   check("jpc_pos", 32'(pc_out), 32'd47);
        seq(1);
        step(1'b0, 1'b1, 3'd1, 8'hFB, 8'd10);  check("jpc_neg", 32'(pc_out), 32'd6);
        step(1'b0, 1'b1, 3'd2, 8'd33, 8'd6);   check("brfl", 32'(pc_out), 32'd33);

        // Reserved kinds behave as no redirect, with and without stall
        step(1'b0, 1'b1, 3'd5, 8'd99, 8'd0);
        step(1'b1, 1'b1, 3'd7, 8'd99, 8'd0);

        // Single call/return
        step(1'b0, 1'b1, 3'd3, 8'd100, 8'd48); check("call_pc", 32'(pc_out), 32'd100);
        seq(3);
        step(1'b0, 1'b1, 3'd4, 8'd0, 8'd103);  check("ret_pc", 32'(pc_out), 32'd49);

        // Nested calls
        step(1'b0, 1'b1, 3'd3, 8'd120, 8'd104);
        step(1'b0, 1'b1, 3'd3, 8'd150, 8'd121);
        step(1'b0, 1'b1, 3'd3, 8'd200, 8'd151);
        step(1'b0, 1'b1, 3'd4, 8'd0, 8'd201);  check("ret3", 32'(pc_out), 32'd152);
        step(1'b0, 1'b1, 3'd4, 8'd0, 8'd152);  check("ret2", 32'(pc_out), 32'd122);
        step(1'b0, 1'b1, 3'd4, 8'd0, 8'd122);  check("ret1", 32'(pc_out), 32'd105);

        // Address wrap 255 -> 0
        step(1'b0, 1'b1, 3'd0, 8'd250, 8'd105);
        seq(5); check("at255", 32'(pc_out), 32'd255);
        seq(1); check("wrap_pc", 32'(pc_out), 32'd0); check("wrap_ifv", 32'(if_valid), 32'd1);

        // Overflow: nine calls from an empty stack
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 3'd3, 8'(20 * i + 30), 8'(20 * i + 10));
            if (i == 7) check("no_ovf_8", 32'(ras_overflow), 32'd0);
        end
        check("ovf_9", 32'(ras_overflow), 32'd1); check("ovf_jump", 32'(pc_out), 32'd190);
        // Top surviving entry is from the eighth call (br_pc=150)
        step(1'b0, 1'b1, 3'd4, 8'd0, 8'd190); check("ovf_ret", 32'(pc_out), 32'd151);

        // Reset mid-chain clears the stack and sticky flags; RET then underflows
        do_reset();
        step(1'b0, 1'b1, 3'd4, 8'd77, 8'd5);
        check("unf_flag", 32'(ras_underflow), 32'd1); check("unf_pc", 32'(pc_out), 32'd0);

        // Random mix against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_control.md
FETCH_CONTROL -- requirements
Module: fetch_control

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-address width (256-word instruction memory).
REQ-002 Parameter RAS_DEPTH, default 8, return-address-stack entries.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hold PC and outputs (decode not ready).
REQ-006 br_valid  input  1  redirect request from execute, one-cycle pulse.
REQ-007 br_kind  input  3  redirect kind: JR=0, JPC=1, BRFL=2, CALL=3, RET=4; 5-7 reserved.
REQ-008 br_target  input  ADDR_W  absolute target (JR/BRFL/CALL) or two's-complement offset (JPC); ignored for RET.
REQ-009 br_pc  input  ADDR_W  address of the redirecting instruction.
REQ-010 pc_out  output  ADDR_W  fetch address to instruction memory (1-cycle synchronous read).
REQ-011 if_pc  output  ADDR_W  address of the word memory presents this cycle.
REQ-012 if_valid  output  1  memory output this cycle is a valid, non-flushed instruction.
REQ-013 ras_overflow  output  1  sticky: CALL while stack full.
REQ-014 ras_underflow  output  1  sticky: RET while stack empty.

Function
REQ-015 Sequential: no stall, no br_valid -> pc_out <= pc_out+1 modulo 2^ADDR_W (255 -> 0); if_pc <= pc_out; if_valid <= 1.
REQ-016 stall=1, br_valid=0 -> pc_out, if_pc, if_valid hold.
REQ-017 br_valid=1 overrides stall; redirect applied same edge.
REQ-018 JR, BRFL targets: pc_out <= br_target (BRFL condition already resolved by requester).
REQ-019 JPC target: pc_out <= br_pc + 1 + sign-extended br_target, modulo 2^ADDR_W.
REQ-020 CALL: push br_pc+1 onto return stack; pc_out <= br_target.
REQ-021 RET: pop top entry; pc_out <= popped value.
REQ-022 Any redirect: if_valid <= 0 for exactly one cycle (flushes the in-flight wrong-path word); if_pc <= pc_out (don't-care value).
REQ-023 CALL with stack full: push dropped, ras_overflow <= 1, jump still taken.
REQ-024 RET with stack empty: ras_underflow <= 1, pc_out <= 0.
REQ-025 Reserved br_kind with br_valid: treated as no redirect (sequential/stall rules apply).
REQ-026 Redirect latency: new target on pc_out one cycle after br_valid edge; first valid instruction at if_valid two cycles after.

Reset
REQ-027 rst_n low, asynchronously: pc_out=0, if_pc=0, if_valid=0, stack pointer=0 (empty), ras_overflow=0, ras_underflow=0.
REQ-028 First edge after rst_n release: pc_out=1, if_valid=1, if_pc=0.
REQ-029 Reset mid-call-chain discards all stack contents; sticky flags clear only on reset.

Structure
REQ-030 Package fetch_pkg holds ADDR_W, RAS_DEPTH defaults and br_kind encodings.
REQ-031 Sub-module return_stack: LIFO with push, pop, full, empty, top; push and pop never asserted together.

Verification
REQ-032 Release reset, no stall -> pc_out 0,1,2,3; if_valid low first cycle, then high with if_pc trailing pc_out by one.
REQ-033 Free-run to pc_out=255 -> next pc_out=0, if_valid stays 1.
REQ-034 br_valid, JPC, br_pc=41, br_target=5 -> pc_out=47 next cycle, if_valid=0 one cycle; offset 8'hFB from br_pc=10 -> pc_out=6.
REQ-035 CALL br_pc=48 target 100, later RET -> pc_out=100 then 49; nested CALL 104->120, 121->150, 151->200, three RETs -> 152, 122, 105.
REQ-036 Nine CALLs without RET -> ras_overflow=1 on ninth, jump to its target; then RET on empty stack after reset -> ras_underflow=1, pc_out=0.
REQ-037 stall=1 with br_valid JR target 68 same cycle -> pc_out=68; stall alone for 3 cycles -> pc_out, if_pc, if_valid unchanged.
